// File: rtl/las_shift_sequencer.sv
// Multi-cycle left arithmetic shift controller: steps a single-bit shift datapath
// once per clock for 'amount' cycles and reports the result with a sticky overflow flag.

module left_arith_shift #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y,
  output logic             of
);
  assign y  = {a[WIDTH-2:0], 1'b0};
  assign of = a[WIDTH-1] ^ a[WIDTH-2];
endmodule

module las_shift_sequencer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] din,
  input  logic [AMT_W-1:0] amount,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic             ovf
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] acc, acc_nx;
  logic [AMT_W-1:0] cnt, cnt_nx;
  logic             ovf_acc, ovf_acc_nx;
  logic [WIDTH-1:0] dout_nx;
  logic             ovf_nx;
  logic [WIDTH-1:0] step_y;
  logic             step_of;

  left_arith_shift #(.WIDTH(WIDTH)) u_step (
    .a  (acc),
    .y  (step_y),
    .of (step_of)
  );

  // Results are latched on the edge that enters DONE (from the value being
  // written into acc), so dout/ovf are already valid during the done cycle.
  always_comb begin
    state_nx   = state;
    acc_nx     = acc;
    cnt_nx     = cnt;
    ovf_acc_nx = ovf_acc;
    dout_nx    = dout;
    ovf_nx     = ovf;
    case (state)
      IDLE: begin
        if (start) begin
          acc_nx     = din;
          cnt_nx     = amount;
          ovf_acc_nx = 1'b0;
          if (amount != '0) begin
            state_nx = SHIFT;
          end else begin
            state_nx = DONE;
            dout_nx  = din;
            ovf_nx   = 1'b0;
          end
        end
      end
      SHIFT: begin
        if (abort) begin
          state_nx = IDLE;
        end else begin
          acc_nx     = step_y;
          ovf_acc_nx = ovf_acc | step_of;
          cnt_nx     = cnt - AMT_W'(1);
          if (cnt == AMT_W'(1)) begin
            state_nx = DONE;
            dout_nx  = step_y;
            ovf_nx   = ovf_acc | step_of;
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      ovf_acc <= 1'b0;
      dout    <= '0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_nx;
      acc     <= acc_nx;
      cnt     <= cnt_nx;
      ovf_acc <= ovf_acc_nx;
      dout    <= dout_nx;
      ovf     <= ovf_nx;
    end
  end

  assign ready = (state == IDLE);
  assign busy  = (state == SHIFT) || (state == DONE);
  assign done  = (state == DONE);
endmodule

// File: tb/tb_las_shift_sequencer.sv
// Directed bench for las_shift_sequencer: hand-computed results, latency,
// handshake, abort and asynchronous reset behaviour.

module tb_las_shift_sequencer;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] din;
  logic [3:0]  amount;
  logic        ready;
  logic        busy;
  logic        done;
  logic [15:0] dout;
  logic        ovf;

  int unsigned n_vec;
  int unsigned n_err;

  las_shift_sequencer #(.WIDTH(16), .AMT_W(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .abort  (abort),
    .din    (din),
    .amount (amount),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .dout   (dout),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One operation; hold_start keeps start asserted while busy, hold_abort keeps abort high.
  task automatic run_op(input string tag, input logic [15:0] d, input logic [3:0] a,
                        input logic [15:0] exp_dout, input logic exp_ovf,
                        input logic hold_start, input logic hold_abort);
    int unsigned cycles;
    int unsigned extra;
    @(negedge clk);
    check({tag, ".ready_pre"}, 32'(ready), 32'd1);
    start  = 1'b1;
    abort  = hold_abort;
    din    = d;
    amount = a;
    @(posedge clk);
    #1;
    start  = hold_start;
    din    = ~d;
    amount = ~a;
    cycles = 1;
    while (!done && cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    start = 1'b0;
    check({tag, ".latency"}, cycles, 32'(a) + 32'd1);
    check({tag, ".dout"}, 32'(dout), 32'(exp_dout));
    check({tag, ".ovf"}, 32'(ovf), 32'(exp_ovf));
    check({tag, ".busy"}, 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    check({tag, ".done_pulse"}, 32'(done), 32'd0);
    check({tag, ".ready_post"}, 32'(ready), 32'd1);
    if (hold_start) begin
      extra = 0;
      for (int i = 0; i < 6; i++) begin
        if (done) extra++;
        @(posedge clk);
        #1;
      end
      check({tag, ".extra_done"}, extra, 32'd0);
    end
    abort = 1'b0;
  endtask

  initial begin
    int unsigned seen;
    n_vec  = 0;
    n_err  = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    din    = '0;
    amount = '0;
    #12;
    check("rst.ready", 32'(ready), 32'd1);
    check("rst.busy",  32'(busy),  32'd0);
    check("rst.done",  32'(done),  32'd0);
    check("rst.dout",  32'(dout),  32'd0);
    check("rst.ovf",   32'(ovf),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("t1",   16'h0001, 4'd3,  16'h0008, 1'b0, 1'b0, 1'b0);
    run_op("t2a",  16'h4000, 4'd1,  16'h8000, 1'b1, 1'b0, 1'b0);
    run_op("t2b",  16'h8000, 4'd1,  16'h0000, 1'b1, 1'b0, 1'b0);
    run_op("t3",   16'hBEEF, 4'd0,  16'hBEEF, 1'b0, 1'b0, 1'b0);
    run_op("hold", 16'h0003, 4'd4,  16'h0030, 1'b0, 1'b1, 1'b0);

    // abort two cycles into SHIFT
    @(negedge clk);
    start  = 1'b1;
    din    = 16'h1234;
    amount = 4'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("abort.busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort.ready", 32'(ready), 32'd1);
    check("abort.done",  32'(done),  32'd0);
    check("abort.dout",  32'(dout),  32'h0030);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) seen++;
      @(posedge clk);
      #1;
    end
    check("abort.no_done", seen, 32'd0);

    // start+abort in IDLE and abort held in DONE: both ignored
    run_op("abrt_idle", 16'h5A5A, 4'd0, 16'h5A5A, 1'b0, 1'b0, 1'b1);
    run_op("t4",        16'h0001, 4'd15, 16'h8000, 1'b1, 1'b0, 1'b0);

    // asynchronous reset between edges while shifting
    @(negedge clk);
    start  = 1'b1;
    din    = 16'h00FF;
    amount = 4'd10;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst.ready", 32'(ready), 32'd1);
    check("arst.busy",  32'(busy),  32'd0);
    check("arst.done",  32'(done),  32'd0);
    check("arst.dout",  32'(dout),  32'd0);
    check("arst.ovf",   32'(ovf),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 16'h00FF, 4'd2, 16'h03FC, 1'b0, 1'b0, 1'b0);
    run_op("ovf_clr",  16'h0001, 4'd1, 16'h0002, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
